// File: rtl/mips32_pkg.sv
// mips32_pkg: opcodes, field positions, instruction classes and pipeline latch types.
// MIPS32_MUL_EN selects whether opcode 000101 (MUL) decodes as an ALU op or as a NOP.
package mips32_pkg;
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;
    localparam logic [5:0] OP_NOP   = 6'b110000;
    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} iclass_e;
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } ifid_t;
    typedef struct packed {
        iclass_e     cls;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
        logic [4:0]  dst;
    } idex_t;
    typedef struct packed {
        iclass_e     cls;
        logic [31:0] res;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        cond;
    } exmem_t;
    typedef struct packed {
        iclass_e     cls;
        logic [31:0] val;
        logic [4:0]  dst;
    } memwb_t;
    localparam ifid_t  IFID_BUBBLE  = '{ir: {OP_NOP, 26'd0}, npc: 32'd0};
    localparam idex_t  IDEX_BUBBLE  = '{cls: NOP, op: OP_NOP, a: 32'd0, b: 32'd0, imm: 32'd0, npc: 32'd0, dst: 5'd0};
    localparam exmem_t EXMEM_BUBBLE = '{cls: NOP, res: 32'd0, b: 32'd0, dst: 5'd0, cond: 1'b0};
    localparam memwb_t MEMWB_BUBBLE = '{cls: NOP, val: 32'd0, dst: 5'd0};
    function automatic iclass_e op_class(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: return RR_ALU;
`ifdef MIPS32_MUL_EN
            OP_MUL: return RR_ALU;
`endif
            OP_ADDI, OP_SUBI, OP_SLTI: return RM_ALU;
            OP_LW: return LOAD;
            OP_SW: return STORE;
            OP_BNEQZ, OP_BEQZ: return BRANCH;
            OP_HLT: return HALT;
            default: return NOP;
        endcase
    endfunction
endpackage

// File: rtl/mips32_alu.sv
// mips32_alu: combinational EX-stage ALU; loads, stores and branch targets use the add path.
// The multiplier exists only when MIPS32_MUL_EN is defined.
module mips32_alu
    import mips32_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    always_comb begin
        case (op_i)
            OP_SUB, OP_SUBI: y_o = a_i - b_i;
            OP_AND:          y_o = a_i & b_i;
            OP_OR:           y_o = a_i | b_i;
            OP_SLT, OP_SLTI: y_o = {31'd0, $signed(a_i) < $signed(b_i)};
`ifdef MIPS32_MUL_EN
            OP_MUL:          y_o = a_i * b_i;
`endif
            default:         y_o = a_i + b_i;
        endcase
    end
endmodule

// File: rtl/mips32_pipeline_5_stage.sv
// mips32_pipeline_5_stage: 5-stage in-order MIPS32-subset core with unified word memory.
// No interlocks; branches resolve in MEM and squash younger stages. MUL gated by MIPS32_MUL_EN.
module mips32_pipeline_5_stage
    import mips32_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] PC, pc_d;
    logic        HALTED, TAKEN_BRANCH;
    logic        stop_q, stop_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic [5:0]  id_op;
    logic [4:0]  rs, rt, rd;
    iclass_e     id_cls;
    logic [31:0] rs_val, rt_val, imm, alu_a, alu_b, alu_y;
    logic        wb_we, fetch;

    assign id_op  = ifid_q.ir[OP_LSB +: 6];
    assign rs     = ifid_q.ir[RS_LSB +: 5];
    assign rt     = ifid_q.ir[RT_LSB +: 5];
    assign rd     = ifid_q.ir[RD_LSB +: 5];
    assign imm    = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
    assign id_cls = op_class(id_op);
    assign wb_we  = memwb_q.cls inside {RR_ALU, RM_ALU, LOAD} && memwb_q.dst != 5'd0 && !HALTED;
    // Write-first regfile: the value retiring this cycle bypasses into ID.
    assign rs_val = rs == 5'd0 ? 32'd0 : (wb_we && memwb_q.dst == rs) ? memwb_q.val : Reg[rs];
    assign rt_val = rt == 5'd0 ? 32'd0 : (wb_we && memwb_q.dst == rt) ? memwb_q.val : Reg[rt];
    assign alu_a  = idex_q.cls == BRANCH ? idex_q.npc : idex_q.a;
    assign alu_b  = idex_q.cls == RR_ALU ? idex_q.b : idex_q.imm;
    assign TAKEN_BRANCH = exmem_q.cls == BRANCH && exmem_q.cond && !HALTED;
    assign fetch  = !stop_q && id_cls != HALT;

    mips32_alu u_alu (
        .op_i (idex_q.op),
        .a_i  (alu_a),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    always_comb begin
        pc_d    = TAKEN_BRANCH ? exmem_q.res : fetch ? PC + 32'd1 : PC;
        stop_d  = !TAKEN_BRANCH && (stop_q || id_cls == HALT);
        ifid_d  = (!TAKEN_BRANCH && fetch) ? ifid_t'{ir: Mem[PC[AW-1:0]], npc: PC + 32'd1} : IFID_BUBBLE;
        idex_d  = TAKEN_BRANCH ? IDEX_BUBBLE : idex_t'{cls: id_cls, op: id_op, a: rs_val, b: rt_val,
                  imm: imm, npc: ifid_q.npc, dst: id_cls == RR_ALU ? rd : rt};
        exmem_d = TAKEN_BRANCH ? EXMEM_BUBBLE : exmem_t'{cls: idex_q.cls, res: alu_y, b: idex_q.b,
                  dst: idex_q.dst, cond: idex_q.op == OP_BEQZ ? idex_q.a == 32'd0 : idex_q.a != 32'd0};
        memwb_d = memwb_t'{cls: exmem_q.cls, dst: exmem_q.dst,
                  val: exmem_q.cls == LOAD ? Mem[exmem_q.res[AW-1:0]] : exmem_q.res};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC      <= RESET_PC;
            HALTED  <= 1'b0;
            stop_q  <= 1'b0;
            ifid_q  <= IFID_BUBBLE;
            idex_q  <= IDEX_BUBBLE;
            exmem_q <= EXMEM_BUBBLE;
            memwb_q <= MEMWB_BUBBLE;
        end else if (!HALTED) begin
            PC      <= pc_d;
            HALTED  <= memwb_q.cls == HALT;
            stop_q  <= stop_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // Architectural storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wb_we && !rst) Reg[memwb_q.dst] <= memwb_q.val;
        if (exmem_q.cls == STORE && !HALTED && !rst) Mem[exmem_q.res[AW-1:0]] <= exmem_q.b;
    end
endmodule

// File: tb/tb_mips32_pipeline_5_stage.sv
// tb_mips32_pipeline_5_stage: directed programs plus random padded programs checked against
// an instruction-level model; MUL expectations follow MIPS32_MUL_EN.
module tb_mips32_pipeline_5_stage;
    localparam logic [31:0] NOPW = {6'b110000, 26'd0};
    localparam logic [31:0] HLTW = {6'b111111, 26'd0};
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] mm [0:1023];
    logic [31:0] mr [0:31];
    logic [31:0] prog [$];
    int tk, mtk;
    logic [31:0] mpc, snap_pc, snap_r5, snap_m;

    mips32_pipeline_5_stage dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    function automatic logic [31:0] r3(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] i2(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input bit rnd);
        logic [31:0] w;
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            w = i < prog.size() ? prog[i] : (rnd ? $urandom : NOPW);
            mm[i] = w;
            dut.Mem[i] = w;
        end
        for (int k = 0; k < 32; k++) begin
            w = k == 0 ? 32'd0 : (rnd ? $urandom : 32'(k));
            mr[k] = w;
            dut.Reg[k] = w;
        end
    endtask

    task automatic run(output int taken);
        int cyc;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        taken = 0;
        while (!dut.HALTED && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (dut.TAKEN_BRANCH) taken++;
        end
        chk("halted", {31'd0, dut.HALTED}, 32'd1);
    endtask

    task automatic wr(input int r, input logic [31:0] v);
        if (r != 0) mr[r] = v;
    endtask

    task automatic model_run(output int taken, output logic [31:0] pc);
        logic [31:0] ir, a, b, imm, ea;
        int rs, rt, rd;
        pc = 32'd0;
        taken = 0;
        for (int s = 0; s < 5000; s++) begin
            ir = mm[pc[9:0]];
            pc = pc + 1;
            rs = int'(ir[25:21]);
            rt = int'(ir[20:16]);
            rd = int'(ir[15:11]);
            a = mr[rs];
            b = mr[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            ea = a + imm;
            if (ir[31:26] == 6'b111111) break;
            case (ir[31:26])
                6'b000000: wr(rd, a + b);
                6'b000001: wr(rd, a - b);
                6'b000010: wr(rd, a & b);
                6'b000011: wr(rd, a | b);
                6'b000100: wr(rd, $signed(a) < $signed(b) ? 32'd1 : 32'd0);
`ifdef MIPS32_MUL_EN
                6'b000101: wr(rd, a * b);
`endif
                6'b001000: wr(rt, mm[ea[9:0]]);
                6'b001001: mm[ea[9:0]] = b;
                6'b001010: wr(rt, a + imm);
                6'b001011: wr(rt, a - imm);
                6'b001100: wr(rt, $signed(a) < $signed(imm) ? 32'd1 : 32'd0);
                6'b001101: if (a != 0) begin pc = pc + imm; taken++; end
                6'b001110: if (a == 0) begin pc = pc + imm; taken++; end
                default: ;
            endcase
        end
    endtask

    task automatic gen(input int n);
        logic [5:0] rr [6] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101};
        logic [5:0] ri [3] = '{6'b001010, 6'b001011, 6'b001100};
        int kind, k;
        prog.delete();
        for (int g = 0; g < n; g++) begin
            kind = int'($urandom_range(0, 9));
            k = int'($urandom_range(0, 2));
            if (kind < 4)
                prog.push_back(r3(rr[$urandom_range(0, 5)], int'($urandom_range(0, 31)),
                                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31))));
            else if (kind < 6)
                prog.push_back(i2(ri[$urandom_range(0, 2)], int'($urandom_range(0, 31)),
                                  int'($urandom_range(0, 31)), int'($urandom_range(0, 65535))));
            else if (kind == 6)
                prog.push_back(i2(6'b001001, int'($urandom_range(0, 31)), 0, int'($urandom_range(512, 767))));
            else if (kind == 7)
                prog.push_back(i2(6'b001000, int'($urandom_range(0, 31)), 0, int'($urandom_range(512, 767))));
            else if (g + 1 + k <= n)
                prog.push_back(i2(kind == 8 ? 6'b001101 : 6'b001110, 0, int'($urandom_range(0, 31)), 3 * k + 2));
            else
                prog.push_back(NOPW);
            prog.push_back(NOPW);
            prog.push_back(NOPW);
        end
        prog.push_back(HLTW);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_pc", dut.PC, 32'd0);
        chk("rst_halted", {31'd0, dut.HALTED}, 32'd0);
        chk("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        prog = '{i2(6'b001010, 1, 0, 10), i2(6'b001010, 2, 0, 20), i2(6'b001010, 3, 0, 25), NOPW, NOPW,
                 r3(6'b000000, 4, 1, 2), NOPW, NOPW, r3(6'b000000, 5, 4, 3), HLTW};
        setup(0);
        run(tk);
        chk("t1_r0", dut.Reg[0], 32'd0);
        chk("t1_r1", dut.Reg[1], 32'd10);
        chk("t1_r2", dut.Reg[2], 32'd20);
        chk("t1_r3", dut.Reg[3], 32'd25);
        chk("t1_r4", dut.Reg[4], 32'd30);
        chk("t1_r5", dut.Reg[5], 32'd55);

        snap_pc = dut.PC;
        snap_r5 = dut.Reg[5];
        snap_m = dut.Mem[5];
        repeat (10) @(negedge clk);
        chk("frz_pc", dut.PC, snap_pc);
        chk("frz_r5", dut.Reg[5], snap_r5);
        chk("frz_mem", dut.Mem[5], snap_m);
        chk("frz_halted", {31'd0, dut.HALTED}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("hrst_pc", dut.PC, 32'd0);
        chk("hrst_halted", {31'd0, dut.HALTED}, 32'd0);

        prog = '{i2(6'b001010, 1, 0, 100), NOPW, NOPW, i2(6'b001001, 1, 0, 50), NOPW, NOPW,
                 i2(6'b001000, 2, 0, 50), NOPW, NOPW, HLTW};
        setup(0);
        run(tk);
        chk("t2_mem50", dut.Mem[50], 32'd100);
        chk("t2_r2", dut.Reg[2], 32'd100);

        prog = '{i2(6'b001010, 1, 0, 3), NOPW, NOPW, i2(6'b001011, 1, 1, 1), NOPW, NOPW,
                 i2(6'b001101, 0, 1, -4), HLTW};
        setup(0);
        run(tk);
        chk("t3_r1", dut.Reg[1], 32'd0);
        chk("t3_taken", 32'(tk), 32'd2);
        chk("t3_pc", dut.PC, 32'd8);

        prog = '{i2(6'b001010, 0, 0, 7), NOPW, NOPW, i2(6'b001010, 7, 0, -1), i2(6'b001010, 8, 0, 1),
                 NOPW, NOPW, r3(6'b000100, 9, 7, 8), i2(6'b001100, 10, 7, 1), HLTW};
        setup(0);
        run(tk);
        chk("t4_r0", dut.Reg[0], 32'd0);
        chk("t4_slt", dut.Reg[9], 32'd1);
        chk("t4_slti", dut.Reg[10], 32'd1);

        prog = '{i2(6'b001010, 1, 0, 6), i2(6'b001010, 2, 0, 7), NOPW, NOPW, r3(6'b000101, 3, 1, 2), HLTW};
        setup(0);
        run(tk);
`ifdef MIPS32_MUL_EN
        chk("t6_mul", dut.Reg[3], 32'd42);
`else
        chk("t6_mul", dut.Reg[3], 32'd3);
`endif

        prog = '{i2(6'b001010, 1, 0, 1000), NOPW, NOPW, i2(6'b001011, 1, 1, 1), NOPW, NOPW,
                 i2(6'b001101, 0, 1, -4), HLTW};
        setup(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_running", {31'd0, dut.HALTED}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_pc", dut.PC, 32'd0);
        chk("mid_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        for (int t = 0; t < 6; t++) begin
            gen(20);
            setup(1);
            model_run(mtk, mpc);
            run(tk);
            for (int r = 0; r < 32; r++) chk($sformatf("rnd%0d_r%0d", t, r), dut.Reg[r], mr[r]);
            for (int m = 0; m < 1024; m++) chk($sformatf("rnd%0d_m%0d", t, m), dut.Mem[m], mm[m]);
            chk($sformatf("rnd%0d_pc", t), dut.PC, mpc);
            chk($sformatf("rnd%0d_taken", t), 32'(tk), 32'(mtk));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
